// File: rtl/lzc_pkg.sv
// ============================================================================
// Module      : lzc_pkg
// Description : Shared mode encodings and defaults for the LZC normaliser.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lzc_pkg;

   localparam logic LZC_MODE_ZEROS = 1'b0;
   localparam logic LZC_MODE_ONES  = 1'b1;

   localparam int unsigned LZC_DEFAULT_N = 32;
   localparam int unsigned LZC_DEFAULT_M = 5;

endpackage : lzc_pkg

`default_nettype wire

// File: rtl/lzc_count.sv
// ============================================================================
// Module      : lzc_count
// Description : Combinational leading-zero counter built as a binary tree.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lzc_count #(
   parameter int N = 32,
   parameter int M = 5
) (
   input  logic [N-1:0] i_x,
   output logic [M:0]   o_cnt,
   output logic         o_all
);

   // Node j at level l covers bits [j*2^l +: 2^l]; child 2j+1 is the upper half.
   for (genvar l = 0; l <= M; l++) begin : g_lvl
      localparam int NODES = N >> l;
      logic [M:0] w_cnt [NODES];
      logic       w_all [NODES];

      if (l == 0) begin : g_leaf
         for (genvar j = 0; j < NODES; j++) begin : g_bit
            assign w_cnt[j] = {{M{1'b0}}, ~i_x[j]};
            assign w_all[j] = ~i_x[j];
         end
      end else begin : g_node
         localparam logic [M:0] SZ = (M+1)'(1 << (l - 1));
         for (genvar j = 0; j < NODES; j++) begin : g_merge
            assign w_all[j] = g_lvl[l-1].w_all[2*j+1] & g_lvl[l-1].w_all[2*j];
            assign w_cnt[j] = g_lvl[l-1].w_all[2*j+1]
                            ? SZ + g_lvl[l-1].w_cnt[2*j]
                            : g_lvl[l-1].w_cnt[2*j+1];
         end
      end
   end

   assign o_cnt = g_lvl[M].w_cnt[0];
   assign o_all = g_lvl[M].w_all[0];

endmodule : lzc_count

`default_nettype wire

// File: rtl/lzc_normalize_pipe.sv
// ============================================================================
// Module      : lzc_normalize_pipe
// Description : Two-stage leading-run counter and limited normalising shifter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lzc_normalize_pipe
   import lzc_pkg::*;
#(
   parameter int N = 32,
   parameter int M = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic         in_mode,
   input  logic [M:0]   in_lim,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic [M:0]   out_lz,
   output logic [M:0]   out_shift,
   output logic         out_zero,
   output logic         out_limited
);

   localparam logic [M:0] C_N = (M+1)'(N);

   typedef struct packed {
      logic [N-1:0] data;
      logic [M:0]   lz;
      logic [M:0]   lim;
      logic         zero;
   } s1_t;

   typedef struct packed {
      logic [N-1:0] data;
      logic [M:0]   lz;
      logic [M:0]   shift;
      logic         zero;
      logic         limited;
   } s2_t;

   logic         r_s1_valid;
   logic         r_s2_valid;
   s1_t          r_s1;
   s2_t          r_s2;
   s1_t          w_s1_next;
   s2_t          w_s2_next;
   logic         w_s1_load;
   logic         w_s2_load;
   logic [N-1:0] w_cnt_src;
   logic [M:0]   w_lz;
   logic         w_all;
   logic [M:0]   w_shift;
   logic [N-1:0] w_shf [M+1];

   assign w_s2_load = !r_s2_valid || out_ready;
   assign w_s1_load = !r_s1_valid || w_s2_load;
   assign in_ready  = w_s1_load;

   // Counting ones is counting zeros of the complement; the stored operand stays raw.
   assign w_cnt_src = (in_mode == LZC_MODE_ONES) ? ~in_data : in_data;

   lzc_count #(
      .N (N),
      .M (M)
   ) u_count (
      .i_x   (w_cnt_src),
      .o_cnt (w_lz),
      .o_all (w_all)
   );

   always_comb begin
      w_s1_next      = '0;
      w_s1_next.data = in_data;
      w_s1_next.lz   = w_lz;
      w_s1_next.lim  = (in_lim > C_N) ? C_N : in_lim;
      w_s1_next.zero = w_all;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1       <= '0;
      end else if (w_s1_load) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1 <= w_s1_next;
         end
      end
   end

   assign w_shift = (r_s1.lz < r_s1.lim) ? r_s1.lz : r_s1.lim;

   // Log-stage barrel shifter; the top shift bit is only ever set for a full-width shift.
   assign w_shf[0] = r_s1.data;
   for (genvar b = 0; b < M; b++) begin : g_shift
      assign w_shf[b+1] = w_shift[b] ? (w_shf[b] << (1 << b)) : w_shf[b];
   end

   always_comb begin
      w_s2_next         = '0;
      w_s2_next.data    = w_shift[M] ? '0 : w_shf[M];
      w_s2_next.lz      = r_s1.lz;
      w_s2_next.shift   = w_shift;
      w_s2_next.zero    = r_s1.zero;
      w_s2_next.limited = (r_s1.lz > r_s1.lim);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2       <= '0;
      end else if (w_s2_load) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2 <= w_s2_next;
         end
      end
   end

   assign out_valid   = r_s2_valid;
   assign out_data    = r_s2.data;
   assign out_lz      = r_s2.lz;
   assign out_shift   = r_s2.shift;
   assign out_zero    = r_s2.zero;
   assign out_limited = r_s2.limited;

endmodule : lzc_normalize_pipe

`default_nettype wire

// File: tb/tb_lzc_normalize_pipe.sv
// ============================================================================
// Module      : tb_lzc_normalize_pipe
// Description : Directed self-checking bench for lzc_normalize_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lzc_normalize_pipe;

   localparam int N = 32;
   localparam int M = 5;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_data;
   logic         in_mode;
   logic [M:0]   in_lim;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_data;
   logic [M:0]   out_lz;
   logic [M:0]   out_shift;
   logic         out_zero;
   logic         out_limited;

   int tests = 0;
   int fails = 0;

   logic [31:0] tbl     [8] = '{32'h0000_0001, 32'h8000_0000, 32'h00F0_0000, 32'h0000_ABCD,
                                32'h0000_0000, 32'h1234_5678, 32'h0001_0000, 32'h7FFF_FFFF};
   logic [31:0] exp_dat [8] = '{32'h8000_0000, 32'h8000_0000, 32'hF000_0000, 32'hABCD_0000,
                                32'h0000_0000, 32'h91A2_B3C0, 32'h8000_0000, 32'hFFFF_FFFE};
   logic [5:0]  exp_lz  [8] = '{6'd31, 6'd0, 6'd8, 6'd16, 6'd32, 6'd3, 6'd15, 6'd1};

   always #5 clk = ~clk;

   lzc_normalize_pipe #(.N(N), .M(M)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_mode     (in_mode),
      .in_lim      (in_lim),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_lz      (out_lz),
      .out_shift   (out_shift),
      .out_zero    (out_zero),
      .out_limited (out_limited)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, ".out_valid"},   out_valid,   1'b0);
      chk({tag, ".out_data"},    out_data,    32'h0);
      chk({tag, ".out_lz"},      out_lz,      6'd0);
      chk({tag, ".out_shift"},   out_shift,   6'd0);
      chk({tag, ".out_zero"},    out_zero,    1'b0);
      chk({tag, ".out_limited"}, out_limited, 1'b0);
      chk({tag, ".in_ready"},    in_ready,    1'b1);
   endtask

   task automatic run_one(input string tag, input logic [31:0] d, input logic m,
                          input logic [5:0] lim, input logic [5:0] elz, input logic [5:0] esh,
                          input logic [31:0] edata, input logic ez, input logic el);
      @(negedge clk);
      in_valid = 1'b1; in_data = d; in_mode = m; in_lim = lim;
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, ".latency"}, out_valid, 1'b0);
      @(negedge clk);
      chk({tag, ".valid"},   out_valid,   1'b1);
      chk({tag, ".lz"},      out_lz,      elz);
      chk({tag, ".shift"},   out_shift,   esh);
      chk({tag, ".data"},    out_data,    edata);
      chk({tag, ".zero"},    out_zero,    ez);
      chk({tag, ".limited"}, out_limited, el);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        ms1, ms2, s1l, s2l, prev_stall;
      int          sent, recv;
      logic [31:0] sv_data;
      logic [5:0]  sv_lz;

      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; in_lim = 6'd32;
      out_ready = 1'b1;
      #12;
      chk_idle_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      run_one("zero_m0",    32'h0000_0000, 1'b0, 6'd32, 6'd32, 6'd32, 32'h0000_0000, 1'b1, 1'b0);
      run_one("bit15_m0",   32'h0000_8000, 1'b0, 6'd32, 6'd16, 6'd16, 32'h8000_0000, 1'b0, 1'b0);
      run_one("ones_m0",    32'hFFFF_FFFF, 1'b0, 6'd32, 6'd0,  6'd0,  32'hFFFF_FFFF, 1'b0, 1'b0);
      run_one("lim10",      32'h0000_00FF, 1'b0, 6'd10, 6'd24, 6'd10, 32'h0003_FC00, 1'b0, 1'b1);
      run_one("lim40",      32'h0000_00FF, 1'b0, 6'd40, 6'd24, 6'd24, 32'hFF00_0000, 1'b0, 1'b0);
      run_one("f0f_m1",     32'hF0F0_0000, 1'b1, 6'd32, 6'd4,  6'd4,  32'h0F00_0000, 1'b0, 1'b0);
      run_one("ones_m1",    32'hFFFF_FFFF, 1'b1, 6'd32, 6'd32, 6'd32, 32'h0000_0000, 1'b1, 1'b0);
      run_one("lim63",      32'h0000_0001, 1'b0, 6'd63, 6'd31, 6'd31, 32'h8000_0000, 1'b0, 1'b0);
      run_one("lim_eq_lz",  32'h0010_0000, 1'b0, 6'd11, 6'd11, 6'd11, 32'h8000_0000, 1'b0, 1'b0);
      run_one("m1_lim3",    32'hFFFF_0000, 1'b1, 6'd3,  6'd16, 6'd3,  32'hFFF8_0000, 1'b0, 1'b1);

      // Back-to-back stream with out_ready toggling every cycle.
      ms1 = 1'b0; ms2 = 1'b0; sent = 0; recv = 0; prev_stall = 1'b0;
      sv_data = '0; sv_lz = '0;
      for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
         @(negedge clk);
         out_ready = cyc[0];
         in_valid  = (sent < 8);
         in_data   = (sent < 8) ? tbl[sent] : 32'h0;
         in_mode   = 1'b0;
         in_lim    = 6'd32;
         #1;
         chk("stream.in_ready",  in_ready,  !(ms1 && ms2 && !out_ready));
         chk("stream.out_valid", out_valid, ms2);
         if (prev_stall) begin
            chk("stream.hold_data", out_data, sv_data);
            chk("stream.hold_lz",   out_lz,   sv_lz);
         end
         if (out_valid && out_ready) begin
            if (recv < 8) begin
               chk("stream.data", out_data, exp_dat[recv]);
               chk("stream.lz",   out_lz,   exp_lz[recv]);
            end else begin
               chk("stream.extra_result", recv, 7);
            end
            recv++;
         end
         prev_stall = out_valid && !out_ready;
         sv_data    = out_data;
         sv_lz      = out_lz;
         s2l = !ms2 || out_ready;
         s1l = !ms1 || s2l;
         if (in_valid && in_ready) sent++;
         if (s2l) ms2 = ms1;
         if (s1l) ms1 = in_valid;
      end
      in_valid = 1'b0;
      chk("stream.received", recv, 8);
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);

      // Fill both stages, then reset asynchronously between clock edges.
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1234_5678; in_mode = 1'b0; in_lim = 6'd32;
      @(negedge clk);
      in_data = 32'h0000_0001;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("full.in_ready",  in_ready,  1'b0);
      chk("full.out_valid", out_valid, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk_idle_outputs("async_rst");
      #1 rst = 1'b0;
      out_ready = 1'b1;
      run_one("post_rst", 32'h0000_0300, 1'b0, 6'd32, 6'd22, 6'd22, 32'hC000_0000, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_lzc_normalize_pipe

`default_nettype wire
